pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the valid/ready and flush inputs of the IF/ID, ID/EX (DX) and EX/MEM pipeline registers, plus the PC write enable.
- Resolves three hazards by priority: data-memory wait, taken branch/jump redirect, load-use.
- Also keeps saturating stall and flush performance counters and a sticky memory-timeout flag.

Parameters:
- RegAddrWidth, 4, register index width; matches the rd/rs1/rs2 fields of the pipeline registers.
- FlushCycles, 2, cycles fd_flush_o stays asserted after a redirect; legal range 1..7.
- MemTimeout, 255, maximum cycles spent in MEM_WAIT before abort; legal range 1..65535.
- CntWidth, 16, width of the performance counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- id_valid_i  in  1  decode stage holds a valid instruction
- id_rs1_i, id_rs2_i  in  RegAddrWidth  decode source registers
- id_uses_rs1_i, id_uses_rs2_i  in  1  decode instruction reads rs1 / rs2
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_memread_i  in  1  EX instruction is a load
- ex_rd_i  in  RegAddrWidth  EX destination register
- ex_redirect_i  in  1  taken branch/jump resolved in EX
- mem_req_i  in  1  MEM stage has a load/store outstanding
- mem_ack_i  in  1  data-memory response this cycle
- pc_write_en_o  out  1  PC register may update
- fd_ready_o  out  1  IF/ID register may accept (0 = hold)
- fd_flush_o  out  1  clear IF/ID
- dx_valid_o  out  1  valid_i into DX register (0 = bubble)
- dx_flush_o  out  1  pipeline_flush into DX register
- xm_ready_o  out  1  EX/MEM register may advance
- mem_timeout_o  out  1  sticky: a memory wait was aborted
- stall_cycles_o  out  CntWidth  cycles with pc_write_en_o=0
- flush_count_o  out  CntWidth  redirects accepted

Behaviour:
- States: RUN, LOAD_USE, FLUSH, MEM_WAIT. Outputs are combinational from state and inputs; state and counters are registered.
- Reset (async, reset_i=1): state RUN; flush count, wait count, stall_cycles_o, flush_count_o and mem_timeout_o all 0. Outputs while in reset: pc_write_en_o=1, fd_ready_o=1, xm_ready_o=1, fd_flush_o=0, dx_flush_o=0, dx_valid_o=0.
- Default, RUN with no hazard:
  - pc_write_en_o=1, fd_ready_o=1, xm_ready_o=1, flushes 0.
  - dx_valid_o=id_valid_i.
- Load-use condition: ex_valid_i & ex_memread_i & (ex_rd_i!=0) & ((id_uses_rs1_i & id_rs1_i==ex_rd_i) | (id_uses_rs2_i & id_rs2_i==ex_rd_i)).
- RUN evaluation, in priority order:
  1. mem_req_i & !mem_ack_i:
     - Outputs: pc_write_en_o=0, fd_ready_o=0, dx_valid_o=0, xm_ready_o=0.
     - Next state MEM_WAIT; wait count <= 1.
  2. ex_redirect_i:
     - Outputs: fd_flush_o=1, dx_flush_o=1, dx_valid_o=0, pc_write_en_o=1; flush_count_o increments.
     - If FlushCycles>1: next state FLUSH, flush count <= FlushCycles-1. Otherwise stay in RUN.
  3. Load-use:
     - Outputs: pc_write_en_o=0, fd_ready_o=0, dx_valid_o=0 (one bubble).
     - Next state LOAD_USE.
- LOAD_USE:
  - Load-use is not re-evaluated; outputs are the RUN default.
  - ex_redirect_i and mem-wait are handled exactly as in RUN.
  - Next state RUN unless rule 1 or 2 fires.
  - Exactly one bubble per load.
- FLUSH:
  - Outputs: fd_flush_o=1, dx_valid_o=0, pc_write_en_o=1.
  - Flush count decrements; go to RUN when it reaches 1.
  - A new ex_redirect_i reloads FlushCycles-1, asserts dx_flush_o and increments flush_count_o.
  - mem_req_i & !mem_ack_i takes priority and goes to MEM_WAIT; the flush count is discarded.
- MEM_WAIT:
  - Full front stall (same outputs as rule 1). ex_redirect_i is ignored, since EX is held and re-presents it.
  - mem_ack_i=1: outputs revert to the RUN default in that same cycle; next state RUN.
  - Otherwise: wait count increments.
  - When wait count == MemTimeout and no ack: mem_timeout_o <= 1 (sticky until reset); next state RUN, with release outputs that cycle.
- Counters:
  - stall_cycles_o increments on every cycle with pc_write_en_o=0.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-operation: any state returns to RUN immediately; all counters and the timeout flag clear.

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN, LOAD_USE, FLUSH, MEM_WAIT) and a typedef for the hazard-select vector.
- Sub-module load_use_detect: purely combinational comparator implementing the load-use condition; reused by the forwarding unit.

Test Plan:
- Load-use: lw x3 in EX (ex_memread_i=1, ex_rd_i=3), ID reads rs1=3 -> exactly 1 cycle of pc_write_en_o=0, fd_ready_o=0, dx_valid_o=0; RUN next; stall_cycles_o=1.
- Same case with ex_rd_i=0, or id_uses_rs1_i=0 -> no stall; dx_valid_o=id_valid_i.
- Redirect with FlushCycles=2 -> cycle 0: fd_flush_o=1, dx_flush_o=1; cycle 1: fd_flush_o=1, dx_flush_o=0; cycle 2: RUN; flush_count_o=1. A second redirect in cycle 1 extends the flush by 1 and makes flush_count_o=2.
- mem_req_i=1 with ack after 5 cycles, and ex_redirect_i held plus a load-use present -> xm_ready_o=0 for 5 cycles; the redirect is taken the cycle after release; stall_cycles_o=5.
- MemTimeout=4, no ack -> mem_timeout_o rises after 4 wait cycles, state returns to RUN, and the flag stays 1 until reset_i.
- Assert reset_i asynchronously mid-MEM_WAIT -> outputs take their reset values without waiting for a clock edge; counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun,
    StLoadUse,
    StFlush,
    StMemWait
  } state_e;

  typedef struct packed {
    logic mem_wait;
    logic redirect;
    logic load_use;
  } hazard_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in EX writes a register that decode reads.
module load_use_detect #(
  parameter int unsigned RegAddrWidth = 4
) (
  input  logic                    ex_valid_i,
  input  logic                    ex_memread_i,
  input  logic [RegAddrWidth-1:0] ex_rd_i,
  input  logic [RegAddrWidth-1:0] id_rs1_i,
  input  logic [RegAddrWidth-1:0] id_rs2_i,
  input  logic                    id_uses_rs1_i,
  input  logic                    id_uses_rs2_i,
  output logic                    hazard_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign w_rs2_hit = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign hazard_o  = ex_valid_i & ex_memread_i & (ex_rd_i != '0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, redirect and load-use,
// plus saturating stall/flush counters and a sticky memory-timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RegAddrWidth = 4,
  parameter int unsigned FlushCycles  = 2,
  parameter int unsigned MemTimeout   = 255,
  parameter int unsigned CntWidth     = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    id_valid_i,
  input  logic [RegAddrWidth-1:0] id_rs1_i,
  input  logic [RegAddrWidth-1:0] id_rs2_i,
  input  logic                    id_uses_rs1_i,
  input  logic                    id_uses_rs2_i,
  input  logic                    ex_valid_i,
  input  logic                    ex_memread_i,
  input  logic [RegAddrWidth-1:0] ex_rd_i,
  input  logic                    ex_redirect_i,
  input  logic                    mem_req_i,
  input  logic                    mem_ack_i,
  output logic                    pc_write_en_o,
  output logic                    fd_ready_o,
  output logic                    fd_flush_o,
  output logic                    dx_valid_o,
  output logic                    dx_flush_o,
  output logic                    xm_ready_o,
  output logic                    mem_timeout_o,
  output logic [CntWidth-1:0]     stall_cycles_o,
  output logic [CntWidth-1:0]     flush_count_o
);

  localparam logic [2:0]  FlushReload = 3'(FlushCycles - 1);
  localparam logic [15:0] WaitLimit   = 16'(MemTimeout);

  state_e              r_state, w_state_next;
  logic [2:0]          r_flush_cnt, w_flush_cnt_next;
  logic [15:0]         r_wait_cnt, w_wait_cnt_next;
  logic [CntWidth-1:0] r_stall_cnt, r_flush_total;
  logic                r_timeout;
  logic                w_timeout_set;
  logic                w_redirect_accept;
  logic                w_load_use;
  hazard_t             w_hz;

  load_use_detect #(
    .RegAddrWidth(RegAddrWidth)
  ) u_load_use_detect (
    .ex_valid_i   (ex_valid_i),
    .ex_memread_i (ex_memread_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i),
    .id_uses_rs2_i(id_uses_rs2_i),
    .hazard_o     (w_load_use)
  );

  // Prioritised hazard select; load-use only counts from RUN so each load gives one bubble.
  always_comb begin
    w_hz          = '0;
    w_hz.mem_wait = mem_req_i & ~mem_ack_i;
    w_hz.redirect = ex_redirect_i & ~w_hz.mem_wait;
    w_hz.load_use = w_load_use & ~w_hz.mem_wait & ~ex_redirect_i & (r_state == StRun);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= StRun;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_wait_cnt  <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_flush_cnt_next  = r_flush_cnt;
    w_wait_cnt_next   = r_wait_cnt;
    w_timeout_set     = 1'b0;
    w_redirect_accept = 1'b0;
    unique case (r_state)
      StRun, StLoadUse, StFlush: begin
        if (w_hz.mem_wait) begin
          w_state_next    = StMemWait;
          w_wait_cnt_next = 16'd1;
        end else if (w_hz.redirect) begin
          w_redirect_accept = 1'b1;
          if (FlushCycles > 1) begin
            w_state_next     = StFlush;
            w_flush_cnt_next = FlushReload;
          end else begin
            w_state_next = StRun;
          end
        end else if (w_hz.load_use) begin
          w_state_next = StLoadUse;
        end else if (r_state == StFlush) begin
          if (r_flush_cnt <= 3'd1) w_state_next = StRun;
          else w_flush_cnt_next = r_flush_cnt - 3'd1;
        end else begin
          w_state_next = StRun;
        end
      end
      StMemWait: begin
        if (mem_ack_i) begin
          w_state_next = StRun;
        end else if (r_wait_cnt >= WaitLimit) begin
          w_timeout_set = 1'b1;
          w_state_next  = StRun;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 16'd1;
        end
      end
      default: w_state_next = StRun;
    endcase
  end

  always_comb begin
    pc_write_en_o = 1'b1;
    fd_ready_o    = 1'b1;
    fd_flush_o    = 1'b0;
    dx_valid_o    = id_valid_i;
    dx_flush_o    = 1'b0;
    xm_ready_o    = 1'b1;
    if (reset_i) begin
      dx_valid_o = 1'b0;
    end else begin
      unique case (r_state)
        StRun, StLoadUse, StFlush: begin
          if (w_hz.mem_wait) begin
            pc_write_en_o = 1'b0;
            fd_ready_o    = 1'b0;
            dx_valid_o    = 1'b0;
            xm_ready_o    = 1'b0;
          end else if (w_hz.redirect) begin
            fd_flush_o = 1'b1;
            dx_flush_o = 1'b1;
            dx_valid_o = 1'b0;
          end else if (w_hz.load_use) begin
            pc_write_en_o = 1'b0;
            fd_ready_o    = 1'b0;
            dx_valid_o    = 1'b0;
          end else if (r_state == StFlush) begin
            fd_flush_o = 1'b1;
            dx_valid_o = 1'b0;
          end
        end
        StMemWait: begin
          // Ack or timeout releases the stall in the same cycle.
          if (!mem_ack_i && (r_wait_cnt < WaitLimit)) begin
            pc_write_en_o = 1'b0;
            fd_ready_o    = 1'b0;
            dx_valid_o    = 1'b0;
            xm_ready_o    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_stall_cnt   <= '0;
      r_flush_total <= '0;
      r_timeout     <= 1'b0;
    end else begin
      if (!pc_write_en_o && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CntWidth'(1);
      if (w_redirect_accept && (r_flush_total != '1)) begin
        r_flush_total <= r_flush_total + CntWidth'(1);
      end
      if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign flush_count_o  = r_flush_total;
  assign mem_timeout_o  = r_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: table-driven single-cycle vectors plus
// hand-written memory-wait, timeout and asynchronous-reset sequences.
module tb_pipeline_hazard_ctrl;

  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        id_valid_i, id_uses_rs1_i, id_uses_rs2_i;
  logic [3:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        ex_valid_i, ex_memread_i, ex_redirect_i, mem_req_i, mem_ack_i;

  logic        pc_write_en_o, fd_ready_o, fd_flush_o, dx_valid_o, dx_flush_o, xm_ready_o;
  logic        mem_timeout_o;
  logic [15:0] stall_cycles_o, flush_count_o;

  logic        t_pc, t_fdr, t_fdf, t_dxv, t_dxf, t_xmr, t_timeout;
  logic [15:0] t_stall, t_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_valid_i(ex_valid_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_en_o(pc_write_en_o), .fd_ready_o(fd_ready_o), .fd_flush_o(fd_flush_o),
    .dx_valid_o(dx_valid_o), .dx_flush_o(dx_flush_o), .xm_ready_o(xm_ready_o),
    .mem_timeout_o(mem_timeout_o), .stall_cycles_o(stall_cycles_o),
    .flush_count_o(flush_count_o)
  );

  pipeline_hazard_ctrl #(.MemTimeout(4)) u_dut_to (
    .clk_i(clk_i), .reset_i(reset_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
    .ex_valid_i(ex_valid_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .ex_redirect_i(ex_redirect_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_en_o(t_pc), .fd_ready_o(t_fdr), .fd_flush_o(t_fdf),
    .dx_valid_o(t_dxv), .dx_flush_o(t_dxf), .xm_ready_o(t_xmr),
    .mem_timeout_o(t_timeout), .stall_cycles_o(t_stall), .flush_count_o(t_flush)
  );

  typedef struct packed {
    logic       idv;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic       mr;
    logic [3:0] rd;
    logic       rdr;
    logic       mreq;
    logic       mack;
  } in_t;

  typedef struct packed {
    logic        pc;
    logic        fdr;
    logic        fdf;
    logic        dxv;
    logic        dxf;
    logic        xmr;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t want;
  } vec_t;

  vec_t tbl[$];

  function automatic in_t mi(input logic idv, input logic [3:0] rs1, input logic [3:0] rs2,
                             input logic u1, input logic u2, input logic exv, input logic mr,
                             input logic [3:0] rd, input logic rdr, input logic mreq,
                             input logic mack);
    in_t v;
    v = '{idv, rs1, rs2, u1, u2, exv, mr, rd, rdr, mreq, mack};
    return v;
  endfunction

  function automatic exp_t me(input logic pc, input logic fdr, input logic fdf, input logic dxv,
                              input logic dxf, input logic xmr, input logic [15:0] stall,
                              input logic [15:0] flush);
    exp_t e;
    e = '{pc, fdr, fdf, dxv, dxf, xmr, stall, flush};
    return e;
  endfunction

  task automatic add(input in_t i, input exp_t w);
    vec_t v;
    v.in   = i;
    v.want = w;
    tbl.push_back(v);
  endtask

  task automatic set_in(input in_t v);
    id_valid_i    = v.idv;
    id_rs1_i      = v.rs1;
    id_rs2_i      = v.rs2;
    id_uses_rs1_i = v.u1;
    id_uses_rs2_i = v.u2;
    ex_valid_i    = v.exv;
    ex_memread_i  = v.mr;
    ex_rd_i       = v.rd;
    ex_redirect_i = v.rdr;
    mem_req_i     = v.mreq;
    mem_ack_i     = v.mack;
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, req);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t lu;
    //        idv rs1   rs2   u1 u2 exv mr rd    rdr mreq mack
    add(mi(O, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, O, O, O, I, 16'd0, 16'd0));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, O, I, O, I, 16'd0, 16'd0));
    add(mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, O, O, O), me(O, O, O, O, O, I, 16'd0, 16'd0));
    add(mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, O, O, O), me(I, I, O, I, O, I, 16'd1, 16'd0));
    add(mi(I, 4'd0, 4'd0, I, O, I, I, 4'd0, O, O, O), me(I, I, O, I, O, I, 16'd1, 16'd0));
    add(mi(I, 4'd3, 4'd0, O, O, I, I, 4'd3, O, O, O), me(I, I, O, I, O, I, 16'd1, 16'd0));
    add(mi(I, 4'd2, 4'd5, I, I, I, I, 4'd5, O, O, O), me(O, O, O, O, O, I, 16'd1, 16'd0));
    add(mi(O, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, O, O, O, I, 16'd2, 16'd0));
    add(mi(I, 4'd3, 4'd0, I, O, I, O, 4'd3, O, O, O), me(I, I, O, I, O, I, 16'd2, 16'd0));
    add(mi(I, 4'd3, 4'd0, I, O, O, I, 4'd3, O, O, O), me(I, I, O, I, O, I, 16'd2, 16'd0));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, I, O, O), me(I, I, I, O, I, I, 16'd2, 16'd0));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, I, O, O, I, 16'd2, 16'd1));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, O, I, O, I, 16'd2, 16'd1));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, I, O, O), me(I, I, I, O, I, I, 16'd2, 16'd1));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, I, O, O), me(I, I, I, O, I, I, 16'd2, 16'd2));
    add(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, I, O, O, I, 16'd2, 16'd3));
    add(mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, I, O, O), me(I, I, I, O, I, I, 16'd2, 16'd3));
    add(mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, O, O, O), me(I, I, I, O, O, I, 16'd2, 16'd4));
    add(mi(O, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O), me(I, I, O, O, O, I, 16'd2, 16'd4));

    // Reset with hazards present: outputs must still show the reset values.
    reset_i = 1'b1;
    set_in(mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, I, I, O));
    @(negedge clk_i);
    @(negedge clk_i);
    chk1("rst pc", pc_write_en_o, I);
    chk1("rst fdr", fd_ready_o, I);
    chk1("rst fdf", fd_flush_o, O);
    chk1("rst dxv", dx_valid_o, O);
    chk1("rst dxf", dx_flush_o, O);
    chk1("rst xmr", xm_ready_o, I);
    chk1("rst timeout", mem_timeout_o, O);
    chk16("rst stall", stall_cycles_o, 16'd0);
    chk16("rst flush", flush_count_o, 16'd0);
    set_in(mi(O, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O));
    reset_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      set_in(tbl[i].in);
      @(negedge clk_i);
      chk1($sformatf("v%0d pc", i), pc_write_en_o, tbl[i].want.pc);
      chk1($sformatf("v%0d fdr", i), fd_ready_o, tbl[i].want.fdr);
      chk1($sformatf("v%0d fdf", i), fd_flush_o, tbl[i].want.fdf);
      chk1($sformatf("v%0d dxv", i), dx_valid_o, tbl[i].want.dxv);
      chk1($sformatf("v%0d dxf", i), dx_flush_o, tbl[i].want.dxf);
      chk1($sformatf("v%0d xmr", i), xm_ready_o, tbl[i].want.xmr);
      chk16($sformatf("v%0d stall", i), stall_cycles_o, tbl[i].want.stall);
      chk16($sformatf("v%0d flush", i), flush_count_o, tbl[i].want.flush);
    end

    // Memory wait acked on the 6th cycle, with a redirect and a load-use held meanwhile.
    // The MemTimeout=4 instance sees the same stimulus and times out first.
    lu = mi(I, 4'd3, 4'd0, I, O, I, I, 4'd3, I, I, O);
    for (int c = 0; c < 5; c++) begin
      tick();
      set_in(lu);
      @(negedge clk_i);
      chk1($sformatf("mw%0d xmr", c), xm_ready_o, O);
      chk1($sformatf("mw%0d pc", c), pc_write_en_o, O);
      chk1($sformatf("mw%0d dxv", c), dx_valid_o, O);
      chk1($sformatf("mw%0d fdf", c), fd_flush_o, O);
      chk1($sformatf("to%0d xmr", c), t_xmr, (c < 4) ? O : I);
      chk1($sformatf("to%0d flag", c), t_timeout, O);
    end
    tick();
    lu.mack = I;
    set_in(lu);
    @(negedge clk_i);
    chk1("ack xmr", xm_ready_o, I);
    chk1("ack pc", pc_write_en_o, I);
    chk1("ack dxv", dx_valid_o, I);
    chk1("ack fdf", fd_flush_o, O);
    chk1("ack dxf", dx_flush_o, O);
    chk16("ack stall", stall_cycles_o, 16'd7);
    chk1("to run redirect", t_fdf, I);
    chk1("to flag set", t_timeout, I);
    tick();
    lu.mreq = O;
    lu.mack = O;
    set_in(lu);
    @(negedge clk_i);
    chk1("post fdf", fd_flush_o, I);
    chk1("post dxf", dx_flush_o, I);
    chk16("post flush", flush_count_o, 16'd4);
    tick();
    set_in(mi(O, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O));
    @(negedge clk_i);
    chk1("post2 fdf", fd_flush_o, I);
    chk16("post2 flush", flush_count_o, 16'd5);
    chk16("post2 stall", stall_cycles_o, 16'd7);
    tick();
    @(negedge clk_i);
    chk1("post3 fdf", fd_flush_o, O);
    chk1("to flag sticky", t_timeout, I);
    chk1("main flag clear", mem_timeout_o, O);

    // Asynchronous reset in the middle of a memory wait.
    tick();
    set_in(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, I, O));
    tick();
    @(negedge clk_i);
    chk1("mw2 xmr", xm_ready_o, O);
    chk1("mw2 to flag", t_timeout, I);
    #2;
    reset_i = 1'b1;
    #1;
    chk1("arst pc", pc_write_en_o, I);
    chk1("arst fdr", fd_ready_o, I);
    chk1("arst xmr", xm_ready_o, I);
    chk1("arst dxv", dx_valid_o, O);
    chk1("arst fdf", fd_flush_o, O);
    chk1("arst dxf", dx_flush_o, O);
    chk16("arst stall", stall_cycles_o, 16'd0);
    chk16("arst flush", flush_count_o, 16'd0);
    chk1("arst to flag", t_timeout, O);
    chk16("arst to stall", t_stall, 16'd0);
    chk16("arst to flush", t_flush, 16'd0);
    chk1("arst to pc", t_pc, I);
    chk1("arst to fdr", t_fdr, I);
    chk1("arst to dxv", t_dxv, O);
    chk1("arst to dxf", t_dxf, O);
    set_in(mi(I, 4'd0, 4'd0, O, O, O, O, 4'd0, O, O, O));
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    @(negedge clk_i);
    chk1("rel dxv", dx_valid_o, I);
    chk1("rel pc", pc_write_en_o, I);
    chk1("rel xmr", xm_ready_o, I);
    chk16("rel stall", stall_cycles_o, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
